// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the count display.
//   - active-low seven-segment codes {g,f,e,d,c,b,a} for 0-9, 'U', 'd' and blank
//   - converter FSM state type
//   - scan digit-index width and a BCD-to-segment decode helper
package seg7_pkg;

  localparam int unsigned DIGIT_W = 2;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  // Non-decimal nibbles never occur in practice; they decode to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 8-bit binary to three BCD digits.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   start          - request a conversion; honoured only in IDLE
//   bin[7:0]       - value captured when start is honoured
//   busy           - high while not in IDLE
//   done           - high for the single DONE cycle; digits valid then
//   hundreds/tens/ones[3:0] - BCD result (valid while done is high)
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  conv_state_e r_state;
  // {hundreds, tens, ones, binary} -- binary bits shift up into the BCD field.
  logic [19:0] r_shift;
  logic [2:0]  r_cnt;
  logic [19:0] w_adj;

  // Add-3 correction on every BCD nibble >= 5 before each shift.
  always_comb begin
    w_adj = r_shift;
    for (int i = 0; i < 3; i++) begin
      if (r_shift[8+4*i +: 4] >= 4'd5) begin
        w_adj[8+4*i +: 4] = r_shift[8+4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= {12'd0, bin};
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_shift <= {w_adj[18:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (r_state != IDLE);
  assign done     = (r_state == DONE);
  assign hundreds = r_shift[19:16];
  assign tens     = r_shift[15:12];
  assign ones     = r_shift[11:8];

endmodule

// File: rtl/count_display_driver.sv
// count_display_driver: shows an 8-bit count on a 4-digit common-anode multiplexed
// seven-segment display. Digits 0-2 are the decimal count, digit 3 shows direction
// ('U' up / 'd' down), and the ones-digit decimal point shows pause.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   count[7:0] - value to display
//   dir        - 1 = up, 0 = down
//   pause      - 1 = paused (lights dp on digit 0)
//   seg[6:0]   - segments {g,f,e,d,c,b,a}, active-low, registered
//   dp         - decimal point, active-low, registered
//   an[3:0]    - digit anodes, active-low, an[0] = ones digit, registered
module count_display_driver
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter bit          BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic       dir,
  input  logic       pause,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int unsigned PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(REFRESH_DIV - 1);

  // Change detection and display registers.
  logic [7:0] r_last;
  logic       r_conv_valid;
  logic [3:0] r_hund;
  logic [3:0] r_tens;
  logic [3:0] r_ones;

  logic       w_start;
  logic       w_busy;
  logic       w_done;
  logic [3:0] w_hund;
  logic [3:0] w_tens;
  logic [3:0] w_ones;

  // A change seen while busy is simply re-detected once the converter is idle again.
  assign w_start = ~w_busy & (~r_conv_valid | (count != r_last));

  bin2bcd_seq u_bin2bcd (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .bin      (count),
    .busy     (w_busy),
    .done     (w_done),
    .hundreds (w_hund),
    .tens     (w_tens),
    .ones     (w_ones)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last       <= '0;
      r_conv_valid <= 1'b0;
      r_hund       <= '0;
      r_tens       <= '0;
      r_ones       <= '0;
    end else begin
      if (w_start) begin
        r_last <= count;
      end
      if (w_done) begin
        r_hund       <= w_hund;
        r_tens       <= w_tens;
        r_ones       <= w_ones;
        r_conv_valid <= 1'b1;
      end
    end
  end

  // Scan prescaler and digit index.
  logic [PRESC_W-1:0] r_presc;
  logic [DIGIT_W-1:0] r_digit;
  logic               w_term;
  logic [DIGIT_W-1:0] w_digit_nxt;

  assign w_term      = (r_presc == PRESC_MAX);
  assign w_digit_nxt = w_term ? r_digit + DIGIT_W'(1) : r_digit;

  // Outputs are decoded from the next digit index so they change on the same edge
  // as the index itself.
  logic [6:0] w_seg_nxt;
  logic       w_dp_nxt;
  logic [3:0] w_an_nxt;

  always_comb begin
    w_seg_nxt = SEG_BLANK;
    unique case (w_digit_nxt)
      2'd0: w_seg_nxt = seg_decode(r_ones);
      2'd1: w_seg_nxt = (BLANK_LZ && (r_hund == 4'd0) && (r_tens == 4'd0)) ?
                        SEG_BLANK : seg_decode(r_tens);
      2'd2: w_seg_nxt = (BLANK_LZ && (r_hund == 4'd0)) ? SEG_BLANK : seg_decode(r_hund);
      2'd3: w_seg_nxt = dir ? SEG_U : SEG_D;
      default: w_seg_nxt = SEG_BLANK;
    endcase
    w_dp_nxt = ~((w_digit_nxt == DIGIT_W'(0)) & pause);
    w_an_nxt = ~(4'b0001 << w_digit_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_digit <= '0;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      an      <= 4'hF;
    end else begin
      r_presc <= w_term ? '0 : r_presc + PRESC_W'(1);
      r_digit <= w_digit_nxt;
      seg     <= w_seg_nxt;
      dp      <= w_dp_nxt;
      an      <= w_an_nxt;
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: two instances (leading-zero blanking on and off)
// share stimulus. A behavioural model predicts every output on every cycle from
// decimal arithmetic and a conversion-latency countdown; table vectors and a few
// hand sequences check whole frames and reset behaviour.
module tb_count_display_driver;

  localparam int R = 4;
  localparam logic [6:0] SEGT [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                        7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] count = 8'd0;
  logic       dir = 1'b1;
  logic       pause = 1'b0;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b;
  logic [3:0] an_a, an_b;

  always #5 clk = ~clk;

  count_display_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .count(count), .dir(dir), .pause(pause),
    .seg(seg_a), .dp(dp_a), .an(an_a)
  );

  count_display_driver #(.REFRESH_DIV(R), .BLANK_LZ(1'b0)) dut_nz (
    .clk(clk), .rst(rst), .count(count), .dir(dir), .pause(pause),
    .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int digit_of(input int k);
    return (k / R) % 4;
  endfunction

  function automatic logic [6:0] exp_seg(input int d, input int v, input logic dv,
                                         input logic blank);
    case (d)
      0:       return SEGT[v % 10];
      1:       return (blank && v < 10) ? 7'h7F : SEGT[(v / 10) % 10];
      2:       return (blank && v < 100) ? 7'h7F : SEGT[v / 100];
      default: return dv ? 7'h41 : 7'h21;
    endcase
  endfunction

  int         m_k = 0;      // edges since reset release
  int         m_timer = 0;  // cycles until the captured value reaches the display
  int         m_cap = 0;
  int         m_disp = 0;
  logic       m_valid = 1'b0;
  logic [6:0] e_seg_a = 7'h7F, e_seg_b = 7'h7F;
  logic       e_dp = 1'b1;
  logic [3:0] e_an = 4'hF;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_timer <= 0; m_cap <= 0; m_disp <= 0; m_valid <= 1'b0;
      e_seg_a <= 7'h7F; e_seg_b <= 7'h7F; e_dp <= 1'b1; e_an <= 4'hF;
    end else begin
      m_k     <= m_k + 1;
      e_an    <= ~(4'b0001 << digit_of(m_k + 1));
      e_seg_a <= exp_seg(digit_of(m_k + 1), m_disp, dir, 1'b1);
      e_seg_b <= exp_seg(digit_of(m_k + 1), m_disp, dir, 1'b0);
      e_dp    <= !(digit_of(m_k + 1) == 0 && pause);
      if (m_timer != 0) begin
        m_timer <= m_timer - 1;
        if (m_timer == 1) begin
          m_disp  <= m_cap;
          m_valid <= 1'b1;
        end
      end else if (!m_valid || int'(count) != m_cap) begin
        m_cap   <= int'(count);
        m_timer <= 9;
      end
    end
  end

  task automatic check_model();
    chk("an_a",  an_a,  e_an);
    chk("seg_a", seg_a, e_seg_a);
    chk("dp_a",  dp_a,  e_dp);
    chk("an_b",  an_b,  e_an);
    chk("seg_b", seg_b, e_seg_b);
    chk("dp_b",  dp_b,  e_dp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Watch one full frame and record what each digit showed.
  task automatic observe(output logic [6:0] d0, output logic [6:0] d1, output logic [6:0] d2,
                         output logic [6:0] d3, output logic [6:0] b1, output logic [6:0] b2,
                         output logic p0);
    d0 = 7'h55; d1 = 7'h55; d2 = 7'h55; d3 = 7'h55; b1 = 7'h55; b2 = 7'h55; p0 = 1'bx;
    for (int i = 0; i < 4 * R; i++) begin
      tick();
      case (an_a)
        4'hE: begin d0 = seg_a; p0 = dp_a; end
        4'hD: d1 = seg_a;
        4'hB: d2 = seg_a;
        4'h7: d3 = seg_a;
        default: ;
      endcase
      case (an_b)
        4'hD: b1 = seg_b;
        4'hB: b2 = seg_b;
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic [7:0] cnt;
    logic       dv;
    logic       pv;
    logic [6:0] s0, s1, s2, s3;
    logic [6:0] nz1, nz2;
    logic       dp0;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [6:0] d0, d1, d2, d3, b1, b2;
    logic       p0;

    vecs[0] = '{8'd0,   1'b1, 1'b0, 7'h40, 7'h7F, 7'h7F, 7'h41, 7'h40, 7'h40, 1'b1};
    vecs[1] = '{8'd255, 1'b1, 1'b0, 7'h12, 7'h12, 7'h24, 7'h41, 7'h12, 7'h24, 1'b1};
    vecs[2] = '{8'd105, 1'b0, 1'b1, 7'h12, 7'h40, 7'h79, 7'h21, 7'h40, 7'h79, 1'b0};
    vecs[3] = '{8'd5,   1'b1, 1'b1, 7'h12, 7'h7F, 7'h7F, 7'h41, 7'h40, 7'h40, 1'b0};
    vecs[4] = '{8'd10,  1'b0, 1'b0, 7'h40, 7'h79, 7'h7F, 7'h21, 7'h79, 7'h40, 1'b1};
    vecs[5] = '{8'd200, 1'b1, 1'b0, 7'h40, 7'h40, 7'h24, 7'h41, 7'h40, 7'h24, 1'b1};
    vecs[6] = '{8'd99,  1'b0, 1'b1, 7'h10, 7'h10, 7'h7F, 7'h21, 7'h10, 7'h40, 1'b0};

    // Reset with count=0, dir=1.
    #2 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("start_an", an_a, 4'hE);
    chk("start_seg0", seg_a, 7'h40);
    repeat (3) tick();
    chk("start_an1", an_a, 4'hD);
    chk("start_seg1_blank", seg_a, 7'h7F);

    // Table vectors: full frame after the conversion has settled.
    for (int v = 0; v < 7; v++) begin
      count = vecs[v].cnt; dir = vecs[v].dv; pause = vecs[v].pv;
      repeat (24) tick();
      observe(d0, d1, d2, d3, b1, b2, p0);
      chk($sformatf("vec%0d_d0", v), d0, vecs[v].s0);
      chk($sformatf("vec%0d_d1", v), d1, vecs[v].s1);
      chk($sformatf("vec%0d_d2", v), d2, vecs[v].s2);
      chk($sformatf("vec%0d_d3", v), d3, vecs[v].s3);
      chk($sformatf("vec%0d_nz1", v), b1, vecs[v].nz1);
      chk($sformatf("vec%0d_nz2", v), b2, vecs[v].nz2);
      chk($sformatf("vec%0d_dp0", v), p0, vecs[v].dp0);
    end

    // 7 then 105 on consecutive cycles: both get converted, 105 last.
    dir = 1'b1; pause = 1'b0;
    count = 8'd7;
    tick();
    count = 8'd105;
    repeat (30) tick();
    observe(d0, d1, d2, d3, b1, b2, p0);
    chk("seq105_d0", d0, 7'h12);
    chk("seq105_d1", d1, 7'h40);
    chk("seq105_d2", d2, 7'h79);

    // Reset four cycles into SHIFT, then a fresh conversion after release.
    count = 8'd77;
    tick();   // capture edge
    repeat (4) tick();
    rst = 1'b1;
    #1;
    chk("midrst_seg", seg_a, 7'h7F);
    chk("midrst_dp", dp_a, 1'b1);
    chk("midrst_an", an_a, 4'hF);
    repeat (2) tick();
    rst = 1'b0;
    repeat (24) tick();
    observe(d0, d1, d2, d3, b1, b2, p0);
    chk("postrst_d0", d0, 7'h78);
    chk("postrst_d1", d1, 7'h78);
    chk("postrst_d2", d2, 7'h7F);

    // Randomized stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      if ($urandom_range(0, 7) == 0) count = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) dir = ~dir;
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/count_display_driver.md
# count_display_driver

Displays the 8-bit LED counter value on the board's 4-digit, common-anode, time-multiplexed seven-segment display. Sits directly downstream of the bi-directional counter and consumes its `count`, `dir` and `pause` signals. A sequential double-dabble converter turns `count` into three BCD digits. Digit 3 shows the count direction, and the ones-digit decimal point shows pause.

## Interface
- `REFRESH_DIV`, default 100000: clk cycles each digit stays selected (1 ms at 100 MHz); legal range ≥ 2.
- `BLANK_LZ`, default 1: 1 = blank leading zeros in the hundreds and tens digits.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `count` in 8: binary value to display (0–255).
- `dir` in 1: 1 = up, 0 = down.
- `pause` in 1: 1 = counter paused.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.
- `dp` out 1: decimal point, active-low.
- `an` out 4: digit anode enables, active-low; an[0] is the ones digit.

## Operation
- Reset values:
  - `seg`=7'h7F, `dp`=1, `an`=4'hF.
  - BCD display registers = 0; converter in IDLE.
  - Scan digit = 0; prescaler = 0; `conv_valid` = 0.
- Converter FSM, states IDLE → SHIFT → DONE → IDLE:
  - **IDLE:** if `conv_valid`=0 or `count` ≠ `last_count`, capture `count` into the shift register and `last_count`, then go to SHIFT.
  - **SHIFT:** exactly 8 cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left 1 bit.
  - **DONE:** write hundreds/tens/ones into the display registers, set `conv_valid`=1, return to IDLE.
- `count` changes during SHIFT/DONE are ignored. IDLE detects the new value on the next pass and converts it; no value that has been stable for ≥ 10 cycles is ever lost.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1.
  - On terminal count, the digit index advances 0→1→2→3→0.
  - Only the selected anode is low.
- Digit content:
  - 0 = ones.
  - 1 = tens; blank if BLANK_LZ and hundreds=0 and tens=0.
  - 2 = hundreds; blank if BLANK_LZ and hundreds=0.
  - 3 = 'U' (7'h41) if `dir`=1, else 'd' (7'h21).
- Segment codes 0–9: 40,79,24,30,19,12,02,78,00,10 (hex). Blank = 7F.
- `dp`=0 only while digit 0 is selected and `pause`=1; otherwise `dp`=1.
- Reset asserted mid-conversion or mid-scan: immediate return to the reset values. After release, a fresh conversion starts because `conv_valid`=0.

## Timing
- `count` sampled in IDLE at edge N. Display registers update at edge N+9 (8 SHIFT + 1 DONE); the displayed value changes from the next output update.
- Worst-case latency from a `count` change to updated registers is 18 cycles: a change arriving just after a capture waits for the current conversion.
- `seg`/`dp`/`an` are registered and all change on the same edge as the digit index.
- `dir` and `pause` reach the outputs 1 cycle after they are sampled, while their digit is selected.
- Full frame = 4×REFRESH_DIV cycles; no gap between digits.

## Structure
- Package `seg7_pkg`:
  - segment code constants SEG_0..SEG_9, SEG_U, SEG_D, SEG_BLANK;
  - converter state enum {IDLE, SHIFT, DONE};
  - digit-index width constant.
- Sub-module `bin2bcd_seq`:
  - ports: clk, rst, start, bin[7:0], busy, done, hundreds[3:0], tens[3:0], ones[3:0];
  - contains the converter FSM.
- The top level holds change detection, display registers, prescaler, scan mux and segment decode.

## Test plan
- Reset with `count`=0, REFRESH_DIV=4, BLANK_LZ=1 → `an` cycles E,D,B,7 every 4 cycles; `seg` shows 40 on digit 0, 7F on digits 1–2, 41 on digit 3 with `dir`=1.
- `count`=8'd255 held → after 9 cycles the registers hold 2/5/5; digits 0,1,2 show 12,12,24.
- `count`=8'd7 then 8'd105 on the very next cycle → 7 converts first, then 105; final digits 12,40,79 with tens shown as 0 (not blanked because hundreds=1).
- `pause`=1, `dir`=0 → `dp`=0 only while `an`=E; digit 3 shows 21.
- Assert `rst` 4 cycles into SHIFT → outputs immediately 7F/1/F. After release, a new conversion of the current `count` completes 9 cycles later.
- BLANK_LZ=0, `count`=8'd5 → digits 2,1,0 show 40,40,12.
